// File: rtl/gpio_irq_arbiter.sv
// gpio_irq_arbiter
// Round-robin interrupt arbiter for a bank of GPIO channels. It picks one
// pending channel, raises IRQ to the CPU, waits for an acknowledge, pulses the
// channel's clear line, and then waits for the channel's interrupt level to
// fall. If the level does not fall in time, a sticky error flag is set.
module gpio_irq_arbiter #(
  parameter int N_CH       = 8,
  parameter int RES_CYCLES = 3,
  parameter int DRAIN_MAX  = 7
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [N_CH-1:0]          INTR,
  input  logic [N_CH-1:0]          IRQ_MASK,
  input  logic                     IRQ_ACK,
  output logic                     IRQ,
  output logic [$clog2(N_CH)-1:0]  IRQ_ID,
  output logic [N_CH-1:0]          IRQRES,
  output logic                     BUSY,
  output logic                     ERR
);

  localparam int IDW     = $clog2(N_CH);
  localparam int CNT_MAX = (RES_CYCLES > DRAIN_MAX) ? RES_CYCLES : DRAIN_MAX;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]  RES_LAST   = CW'(RES_CYCLES - 1);
  localparam logic [CW-1:0]  DRAIN_LAST = CW'(DRAIN_MAX - 1);
  localparam logic [IDW-1:0] ID_LAST    = IDW'(N_CH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]      state;
  logic [IDW-1:0]  ptr;
  logic [CW-1:0]   cnt;
  logic            irq_q;
  logic [IDW-1:0]  irq_id_q;
  logic [N_CH-1:0] irqres_q;
  logic            busy_q;
  logic            err_q;

  logic [N_CH-1:0] pending;
  logic            sel_found;
  logic [IDW-1:0]  sel_idx;
  logic [IDW-1:0]  ptr_after;

  assign pending = INTR & IRQ_MASK;

  // Round-robin pick: first pending channel at or above ptr, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!sel_found && pending[(int'(ptr) + i) % N_CH]) begin
        sel_found = 1'b1;
        sel_idx   = IDW'((int'(ptr) + i) % N_CH);
      end
    end
  end

  // The channel just served drops to lowest priority on the next round.
  always_comb begin
    ptr_after = (irq_id_q == ID_LAST) ? '0 : (irq_id_q + IDW'(1));
  end

  // Arbiter FSM; every output is a flop written alongside the state change,
  // and the counter is cleared whenever a new state is entered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      cnt      <= '0;
      irq_q    <= 1'b0;
      irq_id_q <= '0;
      irqres_q <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_found) begin
            state    <= ST_GRANT;
            irq_id_q <= sel_idx;
            irq_q    <= 1'b1;
            busy_q   <= 1'b1;
            cnt      <= '0;
          end
        end
        ST_GRANT: begin
          if (!pending[irq_id_q]) begin
            state  <= ST_IDLE;
            irq_q  <= 1'b0;
            busy_q <= 1'b0;
            cnt    <= '0;
          end else if (IRQ_ACK) begin
            state    <= ST_CLEAR;
            irq_q    <= 1'b0;
            ptr      <= ptr_after;
            irqres_q <= N_CH'(1) << irq_id_q;
            cnt      <= '0;
          end
        end
        ST_CLEAR: begin
          if (cnt == RES_LAST) begin
            state    <= ST_DRAIN;
            irqres_q <= '0;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DRAIN: begin
          if (!INTR[irq_id_q]) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
          end else if (cnt == DRAIN_LAST) begin
            state  <= ST_IDLE;
            err_q  <= 1'b1;
            busy_q <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          irq_q    <= 1'b0;
          irqres_q <= '0;
          busy_q   <= 1'b0;
          cnt      <= '0;
        end
      endcase
    end
  end

  assign IRQ    = irq_q;
  assign IRQ_ID = irq_id_q;
  assign IRQRES = irqres_q;
  assign BUSY   = busy_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_gpio_irq_arbiter.sv
// tb_gpio_irq_arbiter
// Directed bench for gpio_irq_arbiter with default parameters (8 channels,
// 3-cycle clear pulse, 7-cycle drain limit). Outputs are sampled 1 time unit
// after each rising clock edge.
module tb_gpio_irq_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] intr;
  logic [7:0] irq_mask;
  logic       irq_ack;
  logic       irq;
  logic [2:0] irq_id;
  logic [7:0] irqres;
  logic       busy;
  logic       err;

  int total_checks;
  int passed_checks;

  gpio_irq_arbiter #(.N_CH(8), .RES_CYCLES(3), .DRAIN_MAX(7)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .INTR     (intr),
    .IRQ_MASK (irq_mask),
    .IRQ_ACK  (irq_ack),
    .IRQ      (irq),
    .IRQ_ID   (irq_id),
    .IRQRES   (irqres),
    .BUSY     (busy),
    .ERR      (err)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, " IRQ"},    32'(irq),    32'h0);
    check_output({tag, " IRQ_ID"}, 32'(irq_id), 32'h0);
    check_output({tag, " IRQRES"}, 32'(irqres), 32'h0);
    check_output({tag, " BUSY"},   32'(busy),   32'h0);
    check_output({tag, " ERR"},    32'(err),    32'h0);
  endtask

  // Serve a granted channel like the CPU and a GPIO block would: ack, watch
  // the 3-cycle clear pulse, drop the level, then raise it again.
  task automatic apply_stimulus(input logic [2:0] id);
    check_output("rr IRQ", 32'(irq), 32'h1);
    check_output("rr IRQ_ID", 32'(irq_id), 32'(id));
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check_output("rr IRQRES c1", 32'(irqres), 32'(8'h01 << id));
    step();
    step();
    check_output("rr IRQRES c3", 32'(irqres), 32'(8'h01 << id));
    intr[id] = 1'b0;
    step();
    check_output("rr IRQRES drain", 32'(irqres), 32'h0);
    step();
    check_output("rr BUSY idle", 32'(busy), 32'h0);
    intr[id] = 1'b1;
    step();
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    rst_n    = 1'b0;
    intr     = 8'h00;
    irq_mask = 8'h00;
    irq_ack  = 1'b0;

    // Reset state
    step();
    step();
    check_reset_values("reset");
    rst_n = 1'b1;

    // ACK in IDLE with no interrupts does nothing
    irq_mask = 8'hFF;
    irq_ack  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("idle ack BUSY", 32'(busy), 32'h0);
      check_output("idle ack IRQRES", 32'(irqres), 32'h0);
    end
    irq_ack = 1'b0;

    // Single request on channel 2
    intr = 8'h04;
    step();
    check_output("single IRQ", 32'(irq), 32'h1);
    check_output("single IRQ_ID", 32'(irq_id), 32'h2);
    check_output("single BUSY", 32'(busy), 32'h1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check_output("single IRQ drop", 32'(irq), 32'h0);
    check_output("single IRQRES c1", 32'(irqres), 32'h04);
    step();
    check_output("single IRQRES c2", 32'(irqres), 32'h04);
    step();
    check_output("single IRQRES c3", 32'(irqres), 32'h04);
    intr = 8'h00;
    step();
    check_output("single IRQRES end", 32'(irqres), 32'h00);
    check_output("single BUSY drain", 32'(busy), 32'h1);
    step();
    check_output("single BUSY idle", 32'(busy), 32'h0);
    // ptr is now 3: channels 0 and 3 pending must pick 3
    intr = 8'h09;
    step();
    check_output("single ptr3 IRQ_ID", 32'(irq_id), 32'h3);
    intr = 8'h00;
    step();
    check_output("single withdraw IRQ", 32'(irq), 32'h0);

    // Reset pulse brings ptr back to 0
    rst_n = 1'b0;
    step();
    check_reset_values("reset2");
    rst_n = 1'b1;

    // Round-robin between channels 0 and 7
    intr = 8'h81;
    step();
    apply_stimulus(3'd0);
    apply_stimulus(3'd7);
    apply_stimulus(3'd0);
    apply_stimulus(3'd7);
    check_output("rr regrant IRQ_ID", 32'(irq_id), 32'h0);
    intr = 8'h00;
    step();
    check_output("rr withdraw IRQ", 32'(irq), 32'h0);

    // Withdrawal by masking before ACK
    intr = 8'h10;
    step();
    check_output("wd IRQ_ID", 32'(irq_id), 32'h4);
    check_output("wd IRQ", 32'(irq), 32'h1);
    irq_mask = 8'hEF;
    irq_ack  = 1'b1;
    step();
    irq_ack  = 1'b0;
    check_output("wd IRQ fall", 32'(irq), 32'h0);
    check_output("wd IRQRES", 32'(irqres), 32'h0);
    check_output("wd BUSY", 32'(busy), 32'h0);
    irq_mask = 8'hFF;
    intr     = 8'h30;
    step();
    check_output("wd ptr0 IRQ_ID", 32'(irq_id), 32'h4);
    intr = 8'h00;
    step();

    // Drain timeout on channel 1
    intr = 8'h02;
    step();
    check_output("to IRQ_ID", 32'(irq_id), 32'h1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    step();
    step();
    step();
    check_output("to IRQRES drain", 32'(irqres), 32'h0);
    for (int i = 1; i < 7; i++) begin
      step();
      check_output("to ERR early", 32'(err), 32'h0);
      check_output("to BUSY drain", 32'(busy), 32'h1);
    end
    step();
    check_output("to ERR set", 32'(err), 32'h1);
    check_output("to BUSY idle", 32'(busy), 32'h0);
    step();
    check_output("to regrant IRQ", 32'(irq), 32'h1);
    check_output("to regrant IRQ_ID", 32'(irq_id), 32'h1);
    intr = 8'h00;
    step();
    check_output("to ERR sticky", 32'(err), 32'h1);

    // Reset in the middle of a clear pulse
    intr = 8'h01;
    step();
    check_output("rc IRQ_ID", 32'(irq_id), 32'h0);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    step();
    check_output("rc IRQRES c2", 32'(irqres), 32'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("rc async");
    step();
    rst_n = 1'b1;
    step();
    check_output("rc post IRQ", 32'(irq), 32'h1);
    check_output("rc post IRQ_ID", 32'(irq_id), 32'h0);
    check_output("rc post IRQRES", 32'(irqres), 32'h0);
    intr = 8'h00;
    step();
    check_output("rc final BUSY", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
